// File: rtl/ttt_board_writer_pkg.sv
// ttt_board_writer_pkg: cell/result/scan encodings and win-line evaluation for the tic-tac-toe input path
package ttt_board_writer_pkg;
  localparam logic [1:0] EMPTY = 2'b00, MARK_O = 2'b01, MARK_X = 2'b10;
  localparam logic [1:0] RES_PLAY = 2'b00, RES_O = 2'b01, RES_X = 2'b10, RES_DRAW = 2'b11;
  localparam logic [3:0] SC_CLEAR = 4'd9, SC_NONE = 4'd12, SC_MULTI = 4'd13;
  typedef enum logic [1:0] {IDLE, PRESS, COMMIT, RELEASE} deb_state_t;
  localparam int WIN_LINES [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{2, 5, 8},
                                      '{1, 4, 7}, '{0, 3, 6}, '{2, 4, 6}, '{0, 4, 8}};
  // scan codes are 3*row+col; the board cell index runs column-major from the bottom row
  function automatic logic [3:0] key_cell(input logic [3:0] code);
    key_cell = 4'(3 * int'(code % 4'd3) + 2 - int'(code / 4'd3));
  endfunction
  function automatic logic has_line(input logic [17:0] b, input logic [1:0] m);
    has_line = 1'b0;
    for (int i = 0; i < 8; i++)
      if (b[2*WIN_LINES[i][0] +: 2] == m && b[2*WIN_LINES[i][1] +: 2] == m && b[2*WIN_LINES[i][2] +: 2] == m)
        has_line = 1'b1;
  endfunction
  function automatic logic board_full(input logic [17:0] b);
    board_full = 1'b1;
    for (int k = 0; k < 9; k++)
      if (b[2*k +: 2] == EMPTY) board_full = 1'b0;
  endfunction
endpackage

// File: rtl/ttt_board_writer_key_scan.sv
// ttt_key_scan: keypad column scanner producing one debounced-ready scan code per full 3-column scan
module ttt_key_scan
  import ttt_board_writer_pkg::*;
#(
  parameter int SCAN_DIV = 12500
) (
  input  logic       freq,
  input  logic       rst,
  output logic [2:0] key_col,
  input  logic [3:0] key_row,
  output logic [3:0] scan_code,
  output logic       scan_done
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [DW-1:0] div;
  logic [3:0] row_m, row_s, rows, acc_code, hit_code, new_code;
  logic [1:0] acc_n, new_n, col_idx, row_idx;
  logic [2:0] hits, tot;
  logic wrap;
  assign wrap = div == DW'(SCAN_DIV - 1);
  assign col_idx = key_col[2] ? 2'd2 : key_col[1] ? 2'd1 : 2'd0;
  // keys 0 and # (row 3, columns 1/2) are masked so they read as no key
  assign rows = row_s & (key_col[0] ? 4'b1111 : 4'b0111);
  assign hits = 3'(rows[0]) + 3'(rows[1]) + 3'(rows[2]) + 3'(rows[3]);
  assign row_idx = rows[0] ? 2'd0 : rows[1] ? 2'd1 : rows[2] ? 2'd2 : 2'd3;
  assign hit_code = 4'(row_idx) * 4'd3 + 4'(col_idx);
  assign tot = 3'(acc_n) + hits;
  assign new_n = tot > 3'd1 ? 2'd2 : tot[1:0];
  assign new_code = hits != 3'd0 ? hit_code : acc_code;
  always_ff @(posedge freq or posedge rst)
    if (rst) begin
      div <= '0;
      key_col <= 3'b001;
      row_m <= '0;
      row_s <= '0;
      acc_n <= '0;
      acc_code <= '0;
      scan_code <= SC_NONE;
      scan_done <= 1'b0;
    end else begin
      row_m <= key_row;
      row_s <= row_m;
      scan_done <= 1'b0;
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) begin
        key_col <= {key_col[1:0], key_col[2]};
        if (key_col[2]) begin
          scan_done <= 1'b1;
          scan_code <= new_n == 2'd0 ? SC_NONE : new_n == 2'd1 ? new_code : SC_MULTI;
          acc_n <= '0;
        end else begin
          acc_n <= new_n;
          acc_code <= new_code;
        end
      end
    end
endmodule

// File: rtl/ttt_board_writer.sv
// ttt_board_writer: keypad debounce, move commit, board/turn registers and game result tracking
module ttt_board_writer
  import ttt_board_writer_pkg::*;
#(
  parameter int SCAN_DIV = 12500,
  parameter int DEBOUNCE = 20
) (
  input  logic        freq,
  input  logic        rst,
  output logic [2:0]  key_col,
  input  logic [3:0]  key_row,
  output logic [17:0] board,
  output logic        turn,
  output logic [1:0]  result,
  output logic        move_ok,
  output logic        move_rej
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [3:0] scan_code, code, nxt_code, k;
  logic scan_done, nxt_turn, nxt_ok, nxt_rej;
  logic [CW-1:0] cnt, nxt_cnt;
  logic [17:0] nxt_board;
  logic [1:0] nxt_result, mark;
  deb_state_t state, nxt_state;
  ttt_key_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .freq(freq), .rst(rst), .key_col(key_col), .key_row(key_row),
    .scan_code(scan_code), .scan_done(scan_done)
  );
  always_ff @(posedge freq or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      code <= SC_NONE;
      board <= '0;
      turn <= 1'b0;
      result <= RES_PLAY;
      move_ok <= 1'b0;
      move_rej <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      code <= nxt_code;
      board <= nxt_board;
      turn <= nxt_turn;
      result <= nxt_result;
      move_ok <= nxt_ok;
      move_rej <= nxt_rej;
    end
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    nxt_code = code;
    nxt_board = board;
    nxt_turn = turn;
    nxt_result = result;
    nxt_ok = 1'b0;
    nxt_rej = 1'b0;
    k = key_cell(code);
    mark = turn ? MARK_X : MARK_O;
    case (state)
      IDLE:
        if (scan_done && scan_code < SC_NONE) begin
          nxt_state = PRESS;
          nxt_cnt = CW'(1);
          nxt_code = scan_code;
        end
      PRESS:
        if (cnt == CW'(DEBOUNCE)) nxt_state = COMMIT;
        else if (scan_done) begin
          nxt_cnt = cnt + 1'b1;
          nxt_state = scan_code == code ? PRESS : IDLE;
        end
      COMMIT: begin
        nxt_state = RELEASE;
        nxt_cnt = '0;
        if (code == SC_CLEAR) begin
          nxt_board = '0;
          nxt_turn = 1'b0;
          nxt_result = RES_PLAY;
        end else if (result == RES_PLAY && board[2*k +: 2] == EMPTY) begin
          nxt_board[2*k +: 2] = mark;
          nxt_turn = ~turn;
          nxt_ok = 1'b1;
          // mark encodings double as the winner's result code
          nxt_result = has_line(nxt_board, mark) ? mark : board_full(nxt_board) ? RES_DRAW : RES_PLAY;
        end else nxt_rej = 1'b1;
      end
      RELEASE:
        if (cnt == CW'(DEBOUNCE)) nxt_state = IDLE;
        else if (scan_done) nxt_cnt = scan_code == SC_NONE ? cnt + 1'b1 : '0;
      default: nxt_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ttt_board_writer.sv
// tb_ttt_board_writer: randomized keypad stimulus checked against a behavioural game model
module tb_ttt_board_writer;
  localparam int SCAN = 12;
  logic freq = 1'b0, rst = 1'b0;
  logic [2:0] key_col;
  logic [3:0] key_row;
  logic [17:0] board;
  logic turn, move_ok, move_rej;
  logic [1:0] result;
  logic [11:0] pressed = '0;
  int n_checks = 0, n_fail = 0;
  int m_cell[9];
  int m_turn = 0, m_res = 0, exp_ok = 0, exp_rej = 0, ok_seen = 0, rej_seen = 0;
  int lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{2, 5, 8},
                      '{1, 4, 7}, '{0, 3, 6}, '{2, 4, 6}, '{0, 4, 8}};

  ttt_board_writer #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .freq(freq), .rst(rst), .key_col(key_col), .key_row(key_row), .board(board),
    .turn(turn), .result(result), .move_ok(move_ok), .move_rej(move_rej)
  );

  always #5 freq = ~freq;

  always_comb begin
    key_row = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (key_col[c] && pressed[3*r+c]) key_row[r] = 1'b1;
  end

  function automatic logic [17:0] exp_board();
    logic [17:0] b = '0;
    for (int k = 0; k < 9; k++) b[2*k +: 2] = 2'(m_cell[k]);
    return b;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 9; k++) m_cell[k] = 0;
    m_turn = 0;
    m_res = 0;
  endfunction

  // key codes: 3*row+col, 1..9 -> 0..8, * -> 9, 0 -> 10, # -> 11
  function automatic void model_key(input int code);
    int k, mover, filled;
    bit win;
    exp_ok = 0;
    exp_rej = 0;
    if (code == 9) model_clear();
    else if (code < 9) begin
      k = 3 * (code % 3) + 2 - code / 3;
      if (m_res == 0 && m_cell[k] == 0) begin
        mover = m_turn + 1;
        m_cell[k] = mover;
        m_turn = 1 - m_turn;
        exp_ok = 1;
        win = 0;
        filled = 0;
        foreach (lines[i])
          if (m_cell[lines[i][0]] == mover && m_cell[lines[i][1]] == mover && m_cell[lines[i][2]] == mover) win = 1;
        for (int j = 0; j < 9; j++) if (m_cell[j] != 0) filled++;
        m_res = win ? mover : (filled == 9 ? 3 : 0);
      end else exp_rej = 1;
    end
  endfunction

  task automatic run(input int n);
    repeat (n) begin
      @(negedge freq);
      ok_seen += int'(move_ok);
      rej_seen += int'(move_rej);
    end
  endtask

  task automatic press(input int a, input int b, input int scans);
    if (b < 0) model_key(a);
    else begin
      exp_ok = 0;
      exp_rej = 0;
    end
    ok_seen = 0;
    rej_seen = 0;
    pressed[a] = 1'b1;
    if (b >= 0) pressed[b] = 1'b1;
    run(scans * SCAN);
    pressed = '0;
    run(4 * SCAN);
  endtask

  task automatic test_reset();
    @(negedge freq);
    rst = 1'b1;
    model_clear();
    run(2);
    n_checks++; if (key_col !== 3'b001) begin n_fail++; $display("FAIL reset_col: got %b want 001", key_col); end
    n_checks++; if (board !== 18'h0) begin n_fail++; $display("FAIL reset_board: got %h want 0", board); end
    n_checks++; if ({turn, result, move_ok, move_rej} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {turn, result, move_ok, move_rej}); end
    rst = 1'b0;
    run(4);
    n_checks++; if (key_col !== 3'b010) begin n_fail++; $display("FAIL scan_rotate: got %b want 010", key_col); end
    run(20);
  endtask

  task automatic test_first_move();
    press(4, -1, 3);
    n_checks++; if (board !== 18'h00100) begin n_fail++; $display("FAIL first_board: got %h want 00100", board); end
    n_checks++; if (board !== exp_board()) begin n_fail++; $display("FAIL first_model: got %h want %h", board, exp_board()); end
    n_checks++; if (turn !== 1'b1) begin n_fail++; $display("FAIL first_turn: got %b want 1", turn); end
    n_checks++; if (ok_seen != 1 || rej_seen != 0) begin n_fail++; $display("FAIL first_pulses: got ok=%0d rej=%0d want 1/0", ok_seen, rej_seen); end
  endtask

  task automatic test_hold();
    press(0, -1, 12);
    n_checks++; if (board[5:4] !== 2'b10 || board !== exp_board()) begin n_fail++; $display("FAIL hold_board: got %h want %h", board, exp_board()); end
    n_checks++; if (turn !== 1'b0) begin n_fail++; $display("FAIL hold_turn: got %b want 0", turn); end
    n_checks++; if (ok_seen != 1 || rej_seen != 0) begin n_fail++; $display("FAIL hold_pulses: got ok=%0d rej=%0d want 1/0", ok_seen, rej_seen); end
  endtask

  task automatic test_reject();
    press(4, -1, 3);
    n_checks++; if (board !== exp_board()) begin n_fail++; $display("FAIL rej_board: got %h want %h", board, exp_board()); end
    n_checks++; if (turn !== 1'b0) begin n_fail++; $display("FAIL rej_turn: got %b want 0", turn); end
    n_checks++; if (ok_seen != 0 || rej_seen != 1) begin n_fail++; $display("FAIL rej_pulses: got ok=%0d rej=%0d want 0/1", ok_seen, rej_seen); end
  endtask

  task automatic test_win();
    int seq[5] = '{0, 4, 3, 1, 6};
    press(9, -1, 3);
    n_checks++; if (board !== 18'h0 || turn !== 1'b0 || result !== 2'b00) begin n_fail++; $display("FAIL clear_state: got %h/%b/%b want 0/0/00", board, turn, result); end
    n_checks++; if (ok_seen != 0 || rej_seen != 0) begin n_fail++; $display("FAIL clear_pulses: got ok=%0d rej=%0d want 0/0", ok_seen, rej_seen); end
    foreach (seq[i]) press(seq[i], -1, 3);
    n_checks++; if (result !== 2'b01 || 2'(m_res) !== 2'b01) begin n_fail++; $display("FAIL win_result: got %b want 01", result); end
    n_checks++; if (board !== exp_board()) begin n_fail++; $display("FAIL win_board: got %h want %h", board, exp_board()); end
    press(8, -1, 3);
    n_checks++; if (board !== exp_board() || result !== 2'b01) begin n_fail++; $display("FAIL over_board: got %h/%b want %h/01", board, result, exp_board()); end
    n_checks++; if (ok_seen != 0 || rej_seen != 1) begin n_fail++; $display("FAIL over_pulses: got ok=%0d rej=%0d want 0/1", ok_seen, rej_seen); end
  endtask

  task automatic test_draw();
    int seq[9] = '{4, 0, 8, 2, 1, 7, 6, 3, 5};
    bit empty_cell;
    press(9, -1, 3);
    foreach (seq[i]) begin
      press(seq[i], -1, 3);
      n_checks++; if (result !== 2'(m_res)) begin n_fail++; $display("FAIL draw_step%0d: got %b want %0d", i, result, m_res); end
    end
    empty_cell = 0;
    for (int k = 0; k < 9; k++) if (board[2*k +: 2] == 2'b00) empty_cell = 1;
    n_checks++; if (result !== 2'b11 || empty_cell) begin n_fail++; $display("FAIL draw_result: got %b board=%h want 11 full", result, board); end
    n_checks++; if (board !== exp_board()) begin n_fail++; $display("FAIL draw_board: got %h want %h", board, exp_board()); end
  endtask

  task automatic test_multi_ignored();
    press(9, -1, 3);
    press(4, -1, 3);
    press(0, 1, 6);
    n_checks++; if (ok_seen != 0 || rej_seen != 0 || board !== exp_board()) begin n_fail++; $display("FAIL multi: got ok=%0d rej=%0d board=%h want 0/0 %h", ok_seen, rej_seen, board, exp_board()); end
    press(10, -1, 4);
    press(11, -1, 4);
    n_checks++; if (ok_seen != 0 || rej_seen != 0 || board !== exp_board() || turn !== 1'b1) begin n_fail++; $display("FAIL zero_hash: got ok=%0d rej=%0d board=%h turn=%b want 0/0 %h 1", ok_seen, rej_seen, board, turn, exp_board()); end
  endtask

  task automatic test_reset_mid_press();
    pressed[2] = 1'b1;
    run(14);
    rst = 1'b1;
    model_clear();
    run(1);
    n_checks++; if ({board, turn, result, move_ok, move_rej, key_col} !== {23'b0, 3'b001}) begin n_fail++; $display("FAIL midrst_state: got %h/%b/%b/%b%b/%b want reset values", board, turn, result, move_ok, move_rej, key_col); end
    pressed = '0;
    run(2);
    rst = 1'b0;
    ok_seen = 0;
    rej_seen = 0;
    run(6 * SCAN);
    n_checks++; if (ok_seen != 0 || rej_seen != 0 || board !== 18'h0) begin n_fail++; $display("FAIL midrst_action: got ok=%0d rej=%0d board=%h want 0/0/0", ok_seen, rej_seen, board); end
  endtask

  task automatic test_random_game();
    int code;
    for (int i = 0; i < 40; i++) begin
      code = $urandom_range(0, 11);
      if (code == 9 && $urandom_range(0, 3) != 0) code = $urandom_range(0, 8);
      run($urandom_range(0, SCAN - 1));
      press(code, -1, 3 + $urandom_range(0, 4));
      n_checks++; if (board !== exp_board() || turn !== 1'(m_turn) || result !== 2'(m_res)) begin n_fail++; $display("FAIL rand%0d_state key=%0d: got %h/%b/%b want %h/%0d/%0d", i, code, board, turn, result, exp_board(), m_turn, m_res); end
      n_checks++; if (ok_seen != exp_ok || rej_seen != exp_rej) begin n_fail++; $display("FAIL rand%0d_pulses key=%0d: got ok=%0d rej=%0d want %0d/%0d", i, code, ok_seen, rej_seen, exp_ok, exp_rej); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_first_move();
    test_hold();
    test_reject();
    test_win();
    test_draw();
    test_multi_ignored();
    test_reset_mid_press();
    test_random_game();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
